// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle shift-add multiplier / restoring divider
// that owns HI/LO. The multiply or divide takes WIDTH+2 cycles.
// Ports: clk, reset (sync, active-high); start_i/op_i/rs_i/rt_i start an
// operation; mf_read_i is an MFHI/MFLO read request. busy_o, done_o,
// stall_o and hi_o/lo_o report the state and the result.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             mf_read_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIXUP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_go;
  logic   w_mthi;
  logic   w_mtlo;

  logic [CW-1:0]      r_cnt;
  logic               r_prep;
  logic               r_div;
  logic               r_sgn;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_done;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          unique case (op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              w_go        = 1'b1;
              w_state_nxt = S_ITER;
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      S_ITER: begin
        if (!r_prep && r_cnt == '0)
          w_state_nxt = S_FIXUP;
      end
      S_FIXUP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // First ITER cycle converts the raw operands to magnitudes.
  logic [WIDTH-1:0] w_a_raw;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_d_mag;
  assign w_a_raw = r_p[WIDTH-1:0];
  assign w_a_mag = (r_sgn & w_a_raw[WIDTH-1]) ? -w_a_raw : w_a_raw;
  assign w_d_mag = (r_sgn & r_d[WIDTH-1]) ? -r_d : r_d;

  // Shift-add: multiplier in the low half is consumed LSB first.
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_nxt;
  assign w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                + (r_p[0] ? {1'b0, r_d} : '0);
  assign w_mul_nxt = {w_madd, r_p[WIDTH-1:1]};

  // Restoring divide: remainder high, dividend/quotient low.
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  assign w_diff = {1'b0, r_p[2*WIDTH-1:WIDTH-1]} - {2'b00, r_d};
  assign w_div_nxt = w_diff[WIDTH+1]
                   ? {r_p[2*WIDTH-2:0], 1'b0}
                   : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  assign w_prod  = r_neg_q ? -r_p : r_p;
  assign w_quo   = r_p[WIDTH-1:0];
  assign w_rem   = r_p[2*WIDTH-1:WIDTH];
  assign w_quo_s = r_neg_q ? -w_quo : w_quo;
  assign w_rem_s = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_prep  <= 1'b0;
      r_div   <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
      r_d     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_mthi) r_hi <= rs_i;
      if (w_mtlo) r_lo <= rs_i;
      if (w_go) begin
        r_p    <= {{WIDTH{1'b0}}, rs_i};
        r_d    <= rt_i;
        r_div  <= (op_i == OP_DIV) || (op_i == OP_DIVU);
        r_sgn  <= (op_i == OP_MULT) || (op_i == OP_DIV);
        r_prep <= 1'b1;
        r_cnt  <= CW'(WIDTH - 1);
      end
      if (r_state == S_ITER) begin
        if (r_prep) begin
          r_prep  <= 1'b0;
          r_p     <= {{WIDTH{1'b0}}, w_a_mag};
          r_d     <= w_d_mag;
          r_neg_q <= r_sgn & (w_a_raw[WIDTH-1] ^ r_d[WIDTH-1]);
          r_neg_r <= r_sgn & r_div & w_a_raw[WIDTH-1];
          r_dz    <= r_div & (r_d == '0);
        end else begin
          r_p   <= r_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (r_state == S_FIXUP) begin
        r_done <= 1'b1;
        if (r_div) begin
          r_hi <= r_dz ? '0 : w_rem_s;
          r_lo <= r_dz ? '0 : w_quo_s;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = r_done;
  assign stall_o = mf_read_i & busy_o;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer
// against a cycle-level behavioural model of HI/LO and busy timing.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'd0;
  logic [W-1:0] rs_i = '0;
  logic [W-1:0] rt_i = '0;
  logic         mf_read_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic         stall_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .op_i(op_i),
    .rs_i(rs_i),
    .rt_i(rt_i),
    .mf_read_i(mf_read_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .stall_o(stall_o),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference arithmetic: 64-bit integer math, C-style truncating divide.
  function automatic void calc(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b,
                               output logic [W-1:0] hi,
                               output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    hi = '0;
    lo = '0;
    case (op)
      3'd1: begin
        p = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        p = 64'(q);
        lo = p[31:0];
        p = 64'(r);
        hi = p[31:0];
      end
      3'd4: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
      default: ;
    endcase
  endfunction

  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
          m_done = 1'b1;
        end
      end else if (start_i) begin
        case (op_i)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            calc(op_i, rs_i, rt_i, p_hi, p_lo);
            m_left = LAT;
          end
          3'd5: m_hi = rs_i;
          3'd6: m_lo = rs_i;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy_o}, {63'b0, m_left > 0});
      check("done", {63'b0, done_o}, {63'b0, m_done});
      check("stall", {63'b0, stall_o}, {63'b0, mf_read_i && m_left > 0});
      check("hi", {32'b0, hi_o}, {32'b0, m_hi});
      check("lo", {32'b0, lo_o}, {32'b0, m_lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    tick();
    start_i = 1'b1;
    op_i = op;
    rs_i = a;
    rt_i = b;
    tick();
    start_i = 1'b0;
    op_i = 3'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", {63'b0, done_o}, 64'd1);
  endtask

  task automatic run_chk(input string nm, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(op, a, b);
    wait_done(n);
    check({nm, "_lat"}, 64'(n), 64'(LAT));
    check({nm, "_hi"}, {32'b0, hi_o}, {32'b0, ehi});
    check({nm, "_lo"}, {32'b0, lo_o}, {32'b0, elo});
    tick();
    check({nm, "_done1"}, {63'b0, done_o}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    check("rst_done", {63'b0, done_o}, 64'd0);
    check("rst_hi", {32'b0, hi_o}, 64'd0);
    check("rst_lo", {32'b0, lo_o}, 64'd0);
    reset = 1'b0;

    run_chk("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
    run_chk("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5,
            32'hFFFFFFFF, 32'hFFFFFFF1);
    run_chk("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
    run_chk("divu_z", 3'd4, 32'd7, 32'd0, 32'd0, 32'd0);
    run_chk("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF,
            32'h00000000, 32'h80000000);

    issue(3'd4, 32'd100, 32'd7);
    repeat (4) tick();
    mf_read_i = 1'b1;
    repeat (5) tick();
    start_i = 1'b1;
    op_i = 3'd2;
    rs_i = 32'd5;
    rt_i = 32'd5;
    tick();
    start_i = 1'b0;
    op_i = 3'd0;
    check("stall_mid", {63'b0, stall_o}, 64'd1);
    wait_done(n);
    check("ign_lat", 64'(n), 64'(LAT - 10));
    check("stall_done", {63'b0, stall_o}, 64'd0);
    check("ign_hi", {32'b0, hi_o}, 64'd2);
    check("ign_lo", {32'b0, lo_o}, 64'd14);
    mf_read_i = 1'b0;
    repeat (3) tick();
    check("ign_busy", {63'b0, busy_o}, 64'd0);

    issue(3'd5, 32'h12345678, 32'd0);
    check("mthi_hi", {32'b0, hi_o}, 64'h12345678);
    check("mthi_lo", {32'b0, lo_o}, 64'd14);
    check("mthi_busy", {63'b0, busy_o}, 64'd0);
    issue(3'd6, 32'hCAFEBABE, 32'd0);
    check("mtlo_lo", {32'b0, lo_o}, 64'hCAFEBABE);
    check("mtlo_hi", {32'b0, hi_o}, 64'h12345678);

    issue(3'd4, 32'd1000, 32'd3);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", {63'b0, busy_o}, 64'd0);
    check("abort_hi", {32'b0, hi_o}, 64'd0);
    check("abort_lo", {32'b0, lo_o}, 64'd0);
    check("abort_done", {63'b0, done_o}, 64'd0);
    reset = 1'b0;
    repeat (40) tick();
    run_chk("after_rst", 3'd2, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) :
          $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      issue(op, a, b);
      repeat ($urandom_range(0, 40)) begin
        mf_read_i = 1'($urandom_range(0, 1));
        tick();
      end
    end
    mf_read_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    check("final_idle", {63'b0, busy_o}, 64'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
